// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. Holds a word PC and issues sequential reads to the
// instruction memory. Returned words go into a small prefetch FIFO, and decode
// drains that FIFO over a valid/ready handshake. A redirect flushes the FIFO and
// bumps an epoch bit, so responses that are already in flight get discarded.
module instr_fetch_unit #(
   parameter int DEPTH       = 4,
   parameter int MEM_LATENCY = 1,
   parameter int AW          = 11
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [AW-1:0]             i_start_pc,
   output logic                      o_mem_rden,
   output logic [AW-1:0]             o_mem_addr,
   input  logic [31:0]               i_mem_rdata,
   output logic                      o_instr_valid,
   input  logic                      i_instr_ready,
   output logic [31:0]               o_instr,
   output logic [AW-1:0]             o_instr_pc,
   input  logic                      i_redirect_valid,
   input  logic [AW-1:0]             i_redirect_pc,
   output logic [$clog2(DEPTH):0]    o_fifo_count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int LAST = MEM_LATENCY - 1;

   localparam logic [0:0] S_INIT  = 1'b0;
   localparam logic [0:0] S_FETCH = 1'b1;

   logic [0:0]    r_state;
   logic [AW-1:0] r_pc;
   logic          r_epoch;

   // Tracker stage k holds the request issued k+1 cycles ago.
   // The last stage lines up with the data that is on i_mem_rdata this cycle.
   logic          r_trk_valid [MEM_LATENCY];
   logic          r_trk_epoch [MEM_LATENCY];
   logic [AW-1:0] r_trk_pc    [MEM_LATENCY];

   logic [31:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_fifo_pc   [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [CW:0]   w_inflight;
   logic [CW:0]   w_occupancy;
   logic          w_issue;
   logic          w_write;
   logic          w_pop;
   logic [PW-1:0] w_head_idx;

   // Count the requests still owed a FIFO slot.
   // Stale-epoch requests are counted too, which keeps the FIFO from ever overflowing.
   always_comb begin
      w_inflight = '0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
         w_inflight = w_inflight + {{CW{1'b0}}, r_trk_valid[k]};
      end
   end

   assign w_occupancy = {1'b0, r_count} + w_inflight;
   assign w_issue     = (r_state == S_FETCH) && !i_redirect_valid &&
                        (w_occupancy < (CW+1)'(DEPTH));
   assign w_write     = r_trk_valid[LAST] && (r_trk_epoch[LAST] == r_epoch) &&
                        !i_redirect_valid;
   assign w_pop       = (r_count != '0) && i_instr_ready && !i_redirect_valid;

   // FSM, PC and epoch. A redirect takes priority over a sequential advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_INIT;
         r_pc    <= '0;
         r_epoch <= 1'b0;
      end else begin
         if (i_redirect_valid) begin
            r_epoch <= ~r_epoch;
         end
         if (r_state == S_INIT) begin
            r_state <= S_FETCH;
            r_pc    <= i_start_pc;
         end else if (i_redirect_valid) begin
            r_pc <= i_redirect_pc;
         end else if (w_issue) begin
            r_pc <= r_pc + 1'b1;
         end
      end
   end

   // In-flight tracker: a shift register of {valid, epoch, pc}, one stage per cycle of memory latency.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < MEM_LATENCY; k++) begin
            r_trk_valid[k] <= 1'b0;
            r_trk_epoch[k] <= 1'b0;
            r_trk_pc[k]    <= '0;
         end
      end else begin
         r_trk_valid[0] <= w_issue;
         r_trk_epoch[0] <= r_epoch;
         r_trk_pc[0]    <= r_pc;
         for (int k = 1; k < MEM_LATENCY; k++) begin
            r_trk_valid[k] <= r_trk_valid[k-1];
            r_trk_epoch[k] <= r_trk_epoch[k-1];
            r_trk_pc[k]    <= r_trk_pc[k-1];
         end
      end
   end

   // FIFO pointers and occupancy.
   // A flush moves the read pointer onto the write pointer, so the storage is left untouched.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_redirect_valid) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage. It is cleared on reset so the head outputs read zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_fifo_data[k] <= '0;
            r_fifo_pc[k]   <= '0;
         end
      end else if (w_write) begin
         r_fifo_data[r_wr_ptr] <= i_mem_rdata;
         r_fifo_pc[r_wr_ptr]   <= r_trk_pc[LAST];
      end
   end

   // When the FIFO is empty, show the previously popped slot.
   // That slot cannot be overwritten while the FIFO stays empty, so the last head value holds.
   assign w_head_idx    = (r_count == '0) ? (r_rd_ptr - 1'b1) : r_rd_ptr;
   assign o_instr       = r_fifo_data[w_head_idx];
   assign o_instr_pc    = r_fifo_pc[w_head_idx];
   assign o_instr_valid = (r_count != '0);
   assign o_mem_rden    = w_issue;
   assign o_mem_addr    = r_pc;
   assign o_fifo_count  = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. It drives two instances from the same stimulus:
// one with memory latency 1 and one with memory latency 2.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] start_pc = 11'd0;
   logic        rdy = 1'b0;
   logic        redir = 1'b0;
   logic [10:0] redir_pc = 11'd0;

   logic        rden0, rden1, valid0, valid1;
   logic [10:0] addr0, addr1, ipc0, ipc1;
   logic [31:0] rdata0, rdata1, pipe1, instr0, instr1;
   logic [2:0]  cnt0, cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [10:0] a);
      return 32'hE000_0000 + {21'd0, a};
   endfunction

   // Memory models: one-cycle and two-cycle read latency
   always @(posedge clk) rdata0 <= mem_word(addr0);
   always @(posedge clk) begin
      pipe1  <= mem_word(addr1);
      rdata1 <= pipe1;
   end

   instr_fetch_unit #(.DEPTH(4), .MEM_LATENCY(1), .AW(11)) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_start_pc(start_pc),
      .o_mem_rden(rden0), .o_mem_addr(addr0), .i_mem_rdata(rdata0),
      .o_instr_valid(valid0), .i_instr_ready(rdy), .o_instr(instr0), .o_instr_pc(ipc0),
      .i_redirect_valid(redir), .i_redirect_pc(redir_pc), .o_fifo_count(cnt0)
   );

   instr_fetch_unit #(.DEPTH(4), .MEM_LATENCY(2), .AW(11)) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_start_pc(start_pc),
      .o_mem_rden(rden1), .o_mem_addr(addr1), .i_mem_rdata(rdata1),
      .o_instr_valid(valid1), .i_instr_ready(rdy), .o_instr(instr1), .o_instr_pc(ipc1),
      .i_redirect_valid(redir), .i_redirect_pc(redir_pc), .o_fifo_count(cnt1)
   );

   function automatic logic f_valid(input int d);  return (d == 0) ? valid0 : valid1; endfunction
   function automatic logic f_rden(input int d);   return (d == 0) ? rden0  : rden1;  endfunction
   function automatic logic [10:0] f_addr(input int d);  return (d == 0) ? addr0  : addr1;  endfunction
   function automatic logic [10:0] f_ipc(input int d);   return (d == 0) ? ipc0   : ipc1;   endfunction
   function automatic logic [31:0] f_instr(input int d); return (d == 0) ? instr0 : instr1; endfunction
   function automatic logic [2:0]  f_cnt(input int d);   return (d == 0) ? cnt0   : cnt1;   endfunction

   // One line per accepted instruction
   always @(negedge clk) begin
      if (!rst && rdy && !redir && valid0) $display("  dut0 pop pc=%0d instr=%08h", ipc0, instr0);
      if (!rst && rdy && !redir && valid1) $display("  dut1 pop pc=%0d instr=%08h", ipc1, instr1);
   end

   // Returns at the falling edge inside cycle 0 (state S_INIT)
   task automatic release_reset(input logic [10:0] spc);
      rst      = 1'b1;
      start_pc = spc;
      redir    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++; if (f_rden(d) !== 1'b0) begin n_bad++; $display("FAIL reset_rden d%0d got=%b exp=0", d, f_rden(d)); end
         n_cmp++; if (f_addr(d) !== 11'd0) begin n_bad++; $display("FAIL reset_addr d%0d got=%0d exp=0", d, f_addr(d)); end
         n_cmp++; if (f_valid(d) !== 1'b0) begin n_bad++; $display("FAIL reset_valid d%0d got=%b exp=0", d, f_valid(d)); end
         n_cmp++; if (f_instr(d) !== 32'd0) begin n_bad++; $display("FAIL reset_instr d%0d got=%h exp=0", d, f_instr(d)); end
         n_cmp++; if (f_ipc(d) !== 11'd0) begin n_bad++; $display("FAIL reset_ipc d%0d got=%0d exp=0", d, f_ipc(d)); end
         n_cmp++; if (f_cnt(d) !== 3'd0) begin n_bad++; $display("FAIL reset_cnt d%0d got=%0d exp=0", d, f_cnt(d)); end
      end
   endtask

   task automatic test_stream(input int d);
      int lat = d + 1;
      rdy = 1'b1;
      release_reset(11'd16);
      n_cmp++; if (f_rden(d) !== 1'b0) begin n_bad++; $display("FAIL stream_c0_rden d%0d got=%b exp=0", d, f_rden(d)); end
      @(negedge clk);
      n_cmp++; if (f_rden(d) !== 1'b1) begin n_bad++; $display("FAIL stream_c1_rden d%0d got=%b exp=1", d, f_rden(d)); end
      n_cmp++; if (f_addr(d) !== 11'd16) begin n_bad++; $display("FAIL stream_c1_addr d%0d got=%0d exp=16", d, f_addr(d)); end
      for (int c = 2; c <= lat + 1; c++) begin
         @(negedge clk);
         n_cmp++; if (f_valid(d) !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid d%0d c%0d got=%b exp=0", d, c, f_valid(d)); end
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_cmp++; if (f_valid(d) !== 1'b1) begin n_bad++; $display("FAIL stream_valid d%0d k%0d got=%b exp=1", d, k, f_valid(d)); end
         n_cmp++; if (f_ipc(d) !== 11'(16 + k)) begin n_bad++; $display("FAIL stream_pc d%0d k%0d got=%0d exp=%0d", d, k, f_ipc(d), 16 + k); end
         n_cmp++; if (f_instr(d) !== 32'hE000_0010 + k) begin n_bad++; $display("FAIL stream_instr d%0d k%0d got=%h exp=%h", d, k, f_instr(d), 32'hE000_0010 + k); end
      end
   endtask

   task automatic test_backpressure(input int d);
      rdy = 1'b0;
      release_reset(11'd16);
      repeat (20) @(negedge clk);
      n_cmp++; if (f_cnt(d) !== 3'd4) begin n_bad++; $display("FAIL bp_count d%0d got=%0d exp=4", d, f_cnt(d)); end
      n_cmp++; if (f_rden(d) !== 1'b0) begin n_bad++; $display("FAIL bp_rden d%0d got=%b exp=0", d, f_rden(d)); end
      rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         n_cmp++; if (f_valid(d) !== 1'b1) begin n_bad++; $display("FAIL bp_valid d%0d k%0d got=%b exp=1", d, k, f_valid(d)); end
         n_cmp++; if (f_ipc(d) !== 11'(16 + k)) begin n_bad++; $display("FAIL bp_pc d%0d k%0d got=%0d exp=%0d", d, k, f_ipc(d), 16 + k); end
         n_cmp++; if (f_instr(d) !== 32'hE000_0010 + k) begin n_bad++; $display("FAIL bp_instr d%0d k%0d got=%h exp=%h", d, k, f_instr(d), 32'hE000_0010 + k); end
      end
   endtask

   task automatic test_redirect(input int d);
      int lat = d + 1;
      rdy = 1'b1;
      release_reset(11'd16);
      repeat (5) @(negedge clk);
      redir    = 1'b1;
      redir_pc = 11'd100;
      #1;
      n_cmp++; if (f_rden(d) !== 1'b0) begin n_bad++; $display("FAIL redir_rden d%0d got=%b exp=0", d, f_rden(d)); end
      @(negedge clk);
      redir = 1'b0;
      #1;
      n_cmp++; if (f_valid(d) !== 1'b0) begin n_bad++; $display("FAIL redir_valid_next d%0d got=%b exp=0", d, f_valid(d)); end
      n_cmp++; if (f_rden(d) !== 1'b1) begin n_bad++; $display("FAIL redir_issue d%0d got=%b exp=1", d, f_rden(d)); end
      n_cmp++; if (f_addr(d) !== 11'd100) begin n_bad++; $display("FAIL redir_addr d%0d got=%0d exp=100", d, f_addr(d)); end
      for (int c = 0; c < lat; c++) begin
         @(negedge clk);
         n_cmp++; if (f_valid(d) !== 1'b0) begin n_bad++; $display("FAIL redir_stale_valid d%0d c%0d got=%b exp=0 pc=%0d", d, c, f_valid(d), f_ipc(d)); end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++; if (f_valid(d) !== 1'b1) begin n_bad++; $display("FAIL redir_valid d%0d k%0d got=%b exp=1", d, k, f_valid(d)); end
         n_cmp++; if (f_ipc(d) !== 11'(100 + k)) begin n_bad++; $display("FAIL redir_pc d%0d k%0d got=%0d exp=%0d", d, k, f_ipc(d), 100 + k); end
         n_cmp++; if (f_instr(d) !== 32'hE000_0064 + k) begin n_bad++; $display("FAIL redir_instr d%0d k%0d got=%h exp=%h", d, k, f_instr(d), 32'hE000_0064 + k); end
      end
   endtask

   task automatic test_wrap();
      logic [10:0] exp_pc [4] = '{11'd2046, 11'd2047, 11'd0, 11'd1};
      logic [31:0] exp_in [4] = '{32'hE000_07FE, 32'hE000_07FF, 32'hE000_0000, 32'hE000_0001};
      rdy = 1'b1;
      release_reset(11'd2046);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (valid0 !== 1'b1) begin n_bad++; $display("FAIL wrap_valid k%0d got=%b exp=1", k, valid0); end
         n_cmp++; if (ipc0 !== exp_pc[k]) begin n_bad++; $display("FAIL wrap_pc k%0d got=%0d exp=%0d", k, ipc0, exp_pc[k]); end
         n_cmp++; if (instr0 !== exp_in[k]) begin n_bad++; $display("FAIL wrap_instr k%0d got=%h exp=%h", k, instr0, exp_in[k]); end
      end
   endtask

   task automatic test_redirect_pop_full();
      rdy = 1'b0;
      release_reset(11'd16);
      repeat (12) @(negedge clk);
      n_cmp++; if (cnt0 !== 3'd4) begin n_bad++; $display("FAIL rpf_full got=%0d exp=4", cnt0); end
      rdy      = 1'b1;
      redir    = 1'b1;
      redir_pc = 11'd200;
      #1;
      n_cmp++; if (rden0 !== 1'b0) begin n_bad++; $display("FAIL rpf_rden got=%b exp=0", rden0); end
      @(negedge clk);
      redir = 1'b0;
      rdy   = 1'b0;
      n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL rpf_count got=%0d exp=0", cnt0); end
      n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL rpf_valid got=%b exp=0", valid0); end
      rdy = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (valid0 !== 1'b1) begin n_bad++; $display("FAIL rpf_new_valid got=%b exp=1", valid0); end
      n_cmp++; if (ipc0 !== 11'd200) begin n_bad++; $display("FAIL rpf_new_pc got=%0d exp=200", ipc0); end
   endtask

   task automatic test_async_reset();
      rdy = 1'b1;
      release_reset(11'd16);
      repeat (6) @(negedge clk);
      n_cmp++; if (valid0 !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid got=%b exp=1", valid0); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (valid0 !== 1'b0) begin n_bad++; $display("FAIL arst_valid got=%b exp=0", valid0); end
      n_cmp++; if (rden0 !== 1'b0) begin n_bad++; $display("FAIL arst_rden got=%b exp=0", rden0); end
      n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL arst_count got=%0d exp=0", cnt0); end
      n_cmp++; if (ipc0 !== 11'd0) begin n_bad++; $display("FAIL arst_ipc got=%0d exp=0", ipc0); end
      n_cmp++; if (instr0 !== 32'd0) begin n_bad++; $display("FAIL arst_instr got=%h exp=0", instr0); end
      release_reset(11'd0);
      repeat (3) @(negedge clk);
      n_cmp++; if (valid0 !== 1'b1) begin n_bad++; $display("FAIL arst_restart_valid got=%b exp=1", valid0); end
      n_cmp++; if (ipc0 !== 11'd0) begin n_bad++; $display("FAIL arst_restart_pc got=%0d exp=0", ipc0); end
      n_cmp++; if (instr0 !== 32'hE000_0000) begin n_bad++; $display("FAIL arst_restart_instr got=%h exp=e0000000", instr0); end
   endtask

   initial begin
      test_reset();
      for (int d = 0; d < 2; d++) begin
         test_stream(d);
         test_backpressure(d);
         test_redirect(d);
      end
      test_wrap();
      test_redirect_pop_full();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
